// File: rtl/run_detector.sv
// Per-channel run-length detector: flags runs of RUN_LEN or more identical valid bits.
// Define RUN_DETECTOR_HITCNT_EN to add a saturating 16-bit hit counter per channel.
module run_detector #(
    parameter int unsigned CH      = 1,
    parameter int unsigned RUN_LEN = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CH-1:0]         in_valid,
    input  logic [CH-1:0]         in,
    input  logic                  clr,
    output logic [CH-1:0]         det_zero,
    output logic [CH-1:0]         det_one,
    output logic [CH-1:0]         hit,
    output logic [CH*CNT_W-1:0]   run_cnt,
    output logic [CH*16-1:0]      hit_cnt
);

    localparam logic [CNT_W-1:0] CntMax   = '1;
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RunLen   = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] RunLenM1 = CNT_W'(RUN_LEN - 1);

    logic [CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CH-1:0]            last_q, last_d;
    logic [CH-1:0]            det_zero_q, det_zero_d;
    logic [CH-1:0]            det_one_q, det_one_d;
    logic [CH-1:0]            hit_q, hit_d;

    always_comb begin
        cnt_d      = cnt_q;
        last_d     = last_q;
        det_zero_d = '0;
        det_one_d  = '0;
        hit_d      = '0;
        for (int i = 0; i < int'(CH); i++) begin
            if (clr) begin
                cnt_d[i]  = '0;
                last_d[i] = 1'b0;
            end else if (in_valid[i]) begin
                if (cnt_q[i] == '0 || in[i] != last_q[i]) begin
                    cnt_d[i]  = CntOne;
                    last_d[i] = in[i];
                end else if (cnt_q[i] != CntMax) begin
                    cnt_d[i] = cnt_q[i] + CntOne;
                end
            end
            // Outputs are registered from next state so they land with the sampling edge.
            det_one_d[i]  = (cnt_d[i] >= RunLen) && last_d[i];
            det_zero_d[i] = (cnt_d[i] >= RunLen) && !last_d[i];
            hit_d[i]      = (cnt_d[i] == RunLen) && (cnt_q[i] == RunLenM1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            last_q     <= '0;
            det_zero_q <= '0;
            det_one_q  <= '0;
            hit_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            det_zero_q <= det_zero_d;
            det_one_q  <= det_one_d;
            hit_q      <= hit_d;
        end
    end

    assign det_zero = det_zero_q;
    assign det_one  = det_one_q;
    assign hit      = hit_q;
    assign run_cnt  = cnt_q;

`ifdef RUN_DETECTOR_HITCNT_EN
    logic [CH-1:0][15:0] hcnt_q, hcnt_d;

    always_comb begin
        hcnt_d = hcnt_q;
        for (int i = 0; i < int'(CH); i++) begin
            if (clr) begin
                hcnt_d[i] = '0;
            end else if (hit_d[i] && hcnt_q[i] != 16'hFFFF) begin
                hcnt_d[i] = hcnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
        end
    end

    assign hit_cnt = hcnt_q;
`else
    assign hit_cnt = '0;
`endif

endmodule
